// File: rtl/bulk_endp_arbiter_pkg.sv
// Shared types and helpers for the bulk endpoint arbiter: FSM states,
// DATA PID encodings and the ceil_log2 width helper.
package bulk_endp_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IN    = 2'd1,
      ST_OUT   = 2'd2,
      ST_STALL = 2'd3
   } arb_state_e;

   localparam logic PID_DATA0 = 1'b0;
   localparam logic PID_DATA1 = 1'b1;

   // Smallest r with 2**r >= value; used for counter and index widths.
   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/endp_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits for the IN and OUT directions.
// A flip lands on the next clock; a clear wins over any same-cycle flip.
module endp_toggle_bank
   import bulk_endp_arbiter_pkg::*;
#(
   parameter int NUM_ENDP = 2
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                clr_i,
   input  logic [NUM_ENDP-1:0] in_flip_i,
   input  logic [NUM_ENDP-1:0] out_flip_i,
   output logic [NUM_ENDP-1:0] in_tgl_o,
   output logic [NUM_ENDP-1:0] out_tgl_o
);

   logic [NUM_ENDP-1:0] in_tgl_q, in_tgl_d;
   logic [NUM_ENDP-1:0] out_tgl_q, out_tgl_d;

   // Next toggle state: clear to DATA0 or apply the requested flips.
   always_comb begin
      in_tgl_d  = in_tgl_q;
      out_tgl_d = out_tgl_q;
      if (clr_i) begin
         in_tgl_d  = {NUM_ENDP{PID_DATA0}};
         out_tgl_d = {NUM_ENDP{PID_DATA0}};
      end else begin
         in_tgl_d  = in_tgl_q ^ in_flip_i;
         out_tgl_d = out_tgl_q ^ out_flip_i;
      end
   end

   // Toggle registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         in_tgl_q  <= {NUM_ENDP{PID_DATA0}};
         out_tgl_q <= {NUM_ENDP{PID_DATA0}};
      end else begin
         in_tgl_q  <= in_tgl_d;
         out_tgl_q <= out_tgl_d;
      end
   end

   assign in_tgl_o  = in_tgl_q;
   assign out_tgl_o = out_tgl_q;

endmodule

// File: rtl/bulk_endp_arbiter.sv
// Shares the SIE IN/OUT byte channel between NUM_ENDP bulk endpoints: routes
// strobes to the token's endpoint, tracks data toggles, caps IN packets, stalls unmapped tokens.
module bulk_endp_arbiter
   import bulk_endp_arbiter_pkg::*;
#(
   parameter int NUM_ENDP   = 2,
   parameter int FIRST_ENDP = 1,
   parameter int IN_MPS     = 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  tok_valid_i,
   input  logic                  tok_in_i,
   input  logic [3:0]            tok_endp_i,
   input  logic                  clr_toggle_i,
   input  logic                  sie_in_req_i,
   input  logic                  sie_in_ready_i,
   output logic [7:0]            sie_in_data_o,
   output logic                  sie_in_valid_o,
   output logic                  sie_in_toggle_o,
   input  logic [7:0]            sie_out_data_i,
   input  logic                  sie_out_valid_i,
   input  logic                  sie_out_err_i,
   input  logic                  sie_out_ready_i,
   input  logic                  sie_out_toggle_i,
   output logic                  sie_out_nak_o,
   output logic                  sie_stall_o,
   output logic [NUM_ENDP-1:0]   ep_in_req_o,
   output logic [NUM_ENDP-1:0]   ep_in_ready_o,
   input  logic [8*NUM_ENDP-1:0] ep_in_data_i,
   input  logic [NUM_ENDP-1:0]   ep_in_valid_i,
   output logic [7:0]            ep_out_data_o,
   output logic [NUM_ENDP-1:0]   ep_out_valid_o,
   output logic [NUM_ENDP-1:0]   ep_out_err_o,
   output logic [NUM_ENDP-1:0]   ep_out_ready_o,
   input  logic [NUM_ENDP-1:0]   ep_out_nak_i
);

   localparam int                SEL_W   = (NUM_ENDP > 1) ? ceil_log2(NUM_ENDP) : 1;
   localparam int                CNT_W   = ceil_log2(IN_MPS + 1);
   localparam logic [CNT_W-1:0]  MPS_C   = CNT_W'(IN_MPS);
   localparam logic [4:0]        FIRST_C = 5'(FIRST_ENDP);
   localparam logic [4:0]        LAST_C  = 5'(FIRST_ENDP + NUM_ENDP);

   arb_state_e           state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic                 dup_q, dup_d;
   logic                 seen_q, seen_d;

   logic [NUM_ENDP-1:0]  sel_oh_s;
   logic [NUM_ENDP-1:0]  in_flip_s, out_flip_s;
   logic [NUM_ENDP-1:0]  in_tgl_s, out_tgl_s;
   logic [4:0]           tok_ep_s, tok_idx_s;
   logic                 tok_mapped_s;
   logic                 in_valid_s;
   logic                 dup_s;

   endp_toggle_bank #(
      .NUM_ENDP (NUM_ENDP)
   ) u_toggle_bank (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .clr_i      (clr_toggle_i),
      .in_flip_i  (in_flip_s),
      .out_flip_i (out_flip_s),
      .in_tgl_o   (in_tgl_s),
      .out_tgl_o  (out_tgl_s)
   );

   // Token endpoint decode into a local index.
   always_comb begin
      tok_ep_s     = {1'b0, tok_endp_i};
      tok_idx_s    = tok_ep_s - FIRST_C;
      tok_mapped_s = (tok_ep_s >= FIRST_C) && (tok_ep_s < LAST_C);
   end

   // One-hot form of the selected endpoint.
   always_comb begin
      sel_oh_s = '0;
      for (int k = 0; k < NUM_ENDP; k++) begin
         sel_oh_s[k] = (sel_q == SEL_W'(k));
      end
   end

   // Next-state and routing logic.
   always_comb begin
      state_d         = state_q;
      sel_d           = sel_q;
      byte_cnt_d      = byte_cnt_q;
      dup_d           = dup_q;
      seen_d          = seen_q;
      in_flip_s       = '0;
      out_flip_s      = '0;
      in_valid_s      = 1'b0;
      dup_s           = dup_q;
      sie_in_data_o   = 8'h00;
      sie_in_valid_o  = 1'b0;
      sie_in_toggle_o = PID_DATA0;
      sie_out_nak_o   = 1'b0;
      sie_stall_o     = 1'b0;
      ep_in_req_o     = '0;
      ep_in_ready_o   = '0;
      ep_out_data_o   = 8'h00;
      ep_out_valid_o  = '0;
      ep_out_err_o    = '0;
      ep_out_ready_o  = '0;

      case (state_q)
         ST_IN: begin
            in_valid_s      = ep_in_valid_i[sel_q] && (byte_cnt_q < MPS_C);
            sie_in_valid_o  = in_valid_s;
            sie_in_data_o   = ep_in_data_i[{sel_q, 3'b000} +: 8];
            sie_in_toggle_o = in_tgl_s[sel_q];
            ep_in_req_o     = sie_in_req_i ? sel_oh_s : '0;
            if (sie_in_ready_i && in_valid_s) begin
               ep_in_ready_o = sel_oh_s;
               byte_cnt_d    = byte_cnt_q + CNT_W'(1);
            end else begin
               byte_cnt_d    = byte_cnt_q;
            end
            if (sie_out_err_i) begin
               ep_out_err_o = sel_oh_s;
               state_d      = ST_IDLE;
            end else if (sie_out_ready_i && !sie_out_valid_i) begin
               // Host ACK: the endpoint commits its packet and the PID advances.
               ep_out_ready_o = sel_oh_s;
               in_flip_s      = sel_oh_s;
               state_d        = ST_IDLE;
            end else begin
               state_d = ST_IN;
            end
         end
         ST_OUT: begin
            // A mismatching PID on the first byte marks a retransmission; drop it silently.
            dup_s         = dup_q | (!seen_q && sie_out_valid_i &&
                                     (sie_out_toggle_i != out_tgl_s[sel_q]));
            ep_out_data_o = sie_out_data_i;
            if (sie_out_valid_i) begin
               seen_d = 1'b1;
               dup_d  = dup_s;
            end else begin
               seen_d = seen_q;
            end
            if (!dup_s) begin
               ep_out_valid_o = sie_out_valid_i ? sel_oh_s : '0;
               ep_out_ready_o = sie_out_ready_i ? sel_oh_s : '0;
               sie_out_nak_o  = ep_out_nak_i[sel_q];
            end else begin
               sie_out_nak_o  = 1'b0;
            end
            if (sie_out_err_i) begin
               ep_out_err_o = sel_oh_s;
               state_d      = ST_IDLE;
            end else if (sie_out_ready_i && !sie_out_valid_i) begin
               out_flip_s = (!dup_s && !ep_out_nak_i[sel_q]) ? sel_oh_s : '0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_STALL: begin
            sie_stall_o = 1'b1;
            if (sie_out_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STALL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new token overrides any same-cycle end strobe; no toggle moves.
      if (tok_valid_i) begin
         ep_out_ready_o = '0;
         ep_out_err_o   = '0;
         in_flip_s      = '0;
         out_flip_s     = '0;
         if (tok_mapped_s) begin
            sel_d      = tok_idx_s[SEL_W-1:0];
            byte_cnt_d = '0;
            dup_d      = 1'b0;
            seen_d     = 1'b0;
            state_d    = tok_in_i ? ST_IN : ST_OUT;
         end else begin
            state_d    = ST_STALL;
         end
      end else begin
         sel_d = sel_d;
      end
   end

   // Transaction state registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         byte_cnt_q <= '0;
         dup_q      <= 1'b0;
         seen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         byte_cnt_q <= byte_cnt_d;
         dup_q      <= dup_d;
         seen_q     <= seen_d;
      end
   end

endmodule

// File: tb/tb_bulk_endp_arbiter.sv
// Randomized bench for bulk_endp_arbiter: the bench plays SIE and endpoints
// and predicts routing, packet caps and toggles from per-endpoint queues.
module tb_bulk_endp_arbiter;

   localparam int N     = 2;
   localparam int FIRST = 1;
   localparam int MPS   = 8;

   logic           clk_i = 1'b0;
   logic           rstn_i;
   logic           tok_valid_i, tok_in_i, clr_toggle_i;
   logic [3:0]     tok_endp_i;
   logic           sie_in_req_i, sie_in_ready_i;
   logic [7:0]     sie_in_data_o;
   logic           sie_in_valid_o, sie_in_toggle_o;
   logic [7:0]     sie_out_data_i;
   logic           sie_out_valid_i, sie_out_err_i, sie_out_ready_i, sie_out_toggle_i;
   logic           sie_out_nak_o, sie_stall_o;
   logic [N-1:0]   ep_in_req_o, ep_in_ready_o, ep_in_valid_i;
   logic [8*N-1:0] ep_in_data_i;
   logic [7:0]     ep_out_data_o;
   logic [N-1:0]   ep_out_valid_o, ep_out_err_o, ep_out_ready_o, ep_out_nak_i;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] epq [N][$];
   bit   model_in [N];
   bit   model_out [N];

   bulk_endp_arbiter #(.NUM_ENDP(N), .FIRST_ENDP(FIRST), .IN_MPS(MPS)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .tok_valid_i(tok_valid_i), .tok_in_i(tok_in_i), .tok_endp_i(tok_endp_i),
      .clr_toggle_i(clr_toggle_i),
      .sie_in_req_i(sie_in_req_i), .sie_in_ready_i(sie_in_ready_i),
      .sie_in_data_o(sie_in_data_o), .sie_in_valid_o(sie_in_valid_o),
      .sie_in_toggle_o(sie_in_toggle_o),
      .sie_out_data_i(sie_out_data_i), .sie_out_valid_i(sie_out_valid_i),
      .sie_out_err_i(sie_out_err_i), .sie_out_ready_i(sie_out_ready_i),
      .sie_out_toggle_i(sie_out_toggle_i),
      .sie_out_nak_o(sie_out_nak_o), .sie_stall_o(sie_stall_o),
      .ep_in_req_o(ep_in_req_o), .ep_in_ready_o(ep_in_ready_o),
      .ep_in_data_i(ep_in_data_i), .ep_in_valid_i(ep_in_valid_i),
      .ep_out_data_o(ep_out_data_o), .ep_out_valid_o(ep_out_valid_o),
      .ep_out_err_o(ep_out_err_o), .ep_out_ready_o(ep_out_ready_o),
      .ep_out_nak_i(ep_out_nak_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      tok_valid_i = 1'b0; tok_in_i = 1'b0; tok_endp_i = 4'd0; clr_toggle_i = 1'b0;
      sie_in_req_i = 1'b0; sie_in_ready_i = 1'b0;
      sie_out_data_i = 8'h00; sie_out_valid_i = 1'b0; sie_out_err_i = 1'b0;
      sie_out_ready_i = 1'b0; sie_out_toggle_i = 1'b0;
      ep_in_data_i = '0; ep_in_valid_i = '0; ep_out_nak_i = '0;
   endtask

   task automatic clear_model();
      for (int j = 0; j < N; j++) begin
         model_in[j]  = 1'b0;
         model_out[j] = 1'b0;
      end
   endtask

   task automatic send_tok(input bit is_in, input logic [3:0] ep);
      idle_inputs();
      tok_valid_i = 1'b1; tok_in_i = is_in; tok_endp_i = ep;
      @(negedge clk_i);
      tok_valid_i = 1'b0;
   endtask

   // ack_mode: 0 = host ACK, 1 = ACK lost, 2 = packet error
   task automatic do_in(input int k, input int ack_mode, input bit clr_on_ack);
      int rd, size, guard;
      bit rdy, exp_v;
      send_tok(1'b1, 4'(FIRST + k));
      rd = 0; size = epq[k].size(); guard = 0;
      while (guard < 80) begin
         guard++;
         rdy = 1'($urandom_range(0, 1));
         sie_in_req_i = 1'b1; sie_in_ready_i = rdy;
         for (int j = 0; j < N; j++) begin
            ep_in_valid_i[j] = (j == k) ? (rd < size) : 1'b1;
            ep_in_data_i[8*j +: 8] = (j == k && rd < size) ? epq[k][rd] : 8'($urandom);
         end
         #1;
         exp_v = (rd < size) && (rd < MPS);
         check_eq("in_valid", sie_in_valid_o, exp_v);
         check_eq("in_toggle", sie_in_toggle_o, model_in[k]);
         check_eq("ep_in_req", ep_in_req_o, 32'(1 << k));
         check_eq("ep_in_ready", ep_in_ready_o, (exp_v && rdy) ? 32'(1 << k) : 32'd0);
         if (exp_v) check_eq("in_data", sie_in_data_o, epq[k][rd]);
         if (exp_v && rdy) rd++;
         @(negedge clk_i);
         if (!exp_v) break;
      end
      check_eq("in_guard", guard < 80, 1);
      sie_in_req_i = 1'b0; sie_in_ready_i = 1'b0; ep_in_valid_i = '0;
      if (ack_mode == 0) begin
         sie_out_ready_i = 1'b1; clr_toggle_i = clr_on_ack;
         #1;
         check_eq("in_ack_ready", ep_out_ready_o, 32'(1 << k));
         check_eq("in_ack_err", ep_out_err_o, 0);
         repeat (rd) void'(epq[k].pop_front());
         if (clr_on_ack) clear_model();
         else model_in[k] = ~model_in[k];
      end else if (ack_mode == 2) begin
         sie_out_err_i = 1'b1;
         #1;
         check_eq("in_err", ep_out_err_o, 32'(1 << k));
         check_eq("in_err_ready", ep_out_ready_o, 0);
      end else begin
         #1;
         check_eq("in_lost_ready", ep_out_ready_o, 0);
      end
      @(negedge clk_i);
      idle_inputs();
      if (ack_mode != 1) begin
         sie_in_req_i = 1'b1;
         #1;
         check_eq("in_idle", ep_in_req_o, 0);
         @(negedge clk_i);
         sie_in_req_i = 1'b0;
      end
   endtask

   task automatic do_out(input int k, input int n, input bit tgl, input bit nak,
                         input logic [7:0] base, input bit tok_end);
      bit dup;
      logic [7:0] d;
      send_tok(1'b0, 4'(FIRST + k));
      dup = (n > 0) && (tgl != model_out[k]);
      for (int b = 0; b < n; b++) begin
         d = base + 8'(8'h11 * b);
         sie_out_valid_i = 1'b1; sie_out_ready_i = 1'b1; sie_out_toggle_i = tgl;
         sie_out_data_i = d;
         ep_out_nak_i = N'(nak ? (1 << k) : 0) | N'(~(1 << k));
         #1;
         check_eq("out_valid", ep_out_valid_o, dup ? 32'd0 : 32'(1 << k));
         check_eq("out_ready", ep_out_ready_o, dup ? 32'd0 : 32'(1 << k));
         check_eq("out_data", ep_out_data_o, d);
         check_eq("out_nak", sie_out_nak_o, !dup && nak);
         @(negedge clk_i);
      end
      sie_out_valid_i = 1'b0; sie_out_ready_i = 1'b1;
      tok_valid_i = tok_end; tok_in_i = 1'b0; tok_endp_i = 4'(FIRST + k);
      #1;
      check_eq("out_end_ready", ep_out_ready_o, (dup || tok_end) ? 32'd0 : 32'(1 << k));
      if (!dup && !nak && !tok_end) model_out[k] = ~model_out[k];
      @(negedge clk_i);
      idle_inputs();
      if (!tok_end) begin
         sie_out_valid_i = 1'b1;
         #1;
         check_eq("out_idle", ep_out_valid_o, 0);
         @(negedge clk_i);
         idle_inputs();
      end
   endtask

   task automatic do_stall(input logic [3:0] ep);
      send_tok(1'($urandom_range(0, 1)), ep);
      sie_in_req_i = 1'b1; sie_in_ready_i = 1'b1; sie_out_valid_i = 1'b1;
      ep_in_valid_i = '1;
      #1;
      check_eq("stall", sie_stall_o, 1);
      check_eq("stall_ep_in", {ep_in_req_o, ep_in_ready_o, 7'd0, sie_in_valid_o}, 0);
      check_eq("stall_ep_out", ep_out_valid_o, 0);
      @(negedge clk_i);
      idle_inputs();
      sie_out_ready_i = 1'b1;
      #1;
      check_eq("stall_hold", sie_stall_o, 1);
      check_eq("stall_ready", ep_out_ready_o, 0);
      @(negedge clk_i);
      idle_inputs();
      #1;
      check_eq("stall_leave", sie_stall_o, 0);
   endtask

   function automatic logic [3:0] unmapped_ep();
      logic [3:0] e;
      e = 4'($urandom_range(0, 15));
      while (e >= 4'(FIRST) && e < 4'(FIRST + N)) e = 4'($urandom_range(0, 15));
      return e;
   endfunction

   task automatic pulse_clr();
      idle_inputs();
      clr_toggle_i = 1'b1;
      @(negedge clk_i);
      clr_toggle_i = 1'b0;
      clear_model();
   endtask

   initial begin
      int op, k, n;
      idle_inputs();
      clear_model();
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_outputs", {sie_in_valid_o, sie_in_toggle_o, sie_out_nak_o, sie_stall_o,
                               ep_in_req_o, ep_in_ready_o, ep_out_valid_o, ep_out_err_o,
                               ep_out_ready_o}, 0);
      rstn_i = 1'b1;
      @(negedge clk_i);

      // T1: three bytes, ACK
      epq[0].push_back(8'hA1); epq[0].push_back(8'hA2); epq[0].push_back(8'hA3);
      do_in(0, 0, 1'b0);
      pulse_clr();
      // T2: 12 bytes split 8 + 4
      for (int i = 0; i < 12; i++) epq[0].push_back(8'(8'h10 + i));
      do_in(0, 0, 1'b0);
      do_in(0, 0, 1'b0);
      // T3: lost ACK then resend
      for (int i = 0; i < 3; i++) epq[0].push_back(8'(8'hC0 + i));
      do_in(0, 1, 1'b0);
      do_in(0, 0, 1'b0);
      // T4: OUT then duplicate, T5: NAK
      do_out(1, 2, 1'b0, 1'b0, 8'h55, 1'b0);
      do_out(1, 2, 1'b0, 1'b0, 8'h55, 1'b0);
      do_out(1, 2, model_out[1], 1'b1, 8'h20, 1'b0);
      // T6: unmapped
      do_stall(4'd5);
      do_stall(4'd0);
      // token colliding with end strobe
      do_out(0, 1, model_out[0], 1'b0, 8'h33, 1'b1);
      do_out(0, 1, model_out[0], 1'b0, 8'h44, 1'b0);

      for (int it = 0; it < 150; it++) begin
         op = $urandom_range(0, 9);
         k  = $urandom_range(0, N - 1);
         if (op <= 3) begin
            if (epq[k].size() < 4) begin
               n = $urandom_range(0, 12);
               for (int i = 0; i < n; i++) epq[k].push_back(8'($urandom));
            end
            do_in(k, $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
         end else if (op <= 7) begin
            do_out(k, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 7) == 0));
         end else if (op == 8) begin
            do_stall(unmapped_ep());
         end else begin
            pulse_clr();
         end
      end

      // Reset in the middle of an OUT packet
      do_out(1, 1, model_out[1], 1'b0, 8'h01, 1'b0);
      send_tok(1'b0, 4'(FIRST + 1));
      sie_out_valid_i = 1'b1; sie_out_ready_i = 1'b1; sie_out_toggle_i = model_out[1];
      sie_out_data_i = 8'h9A;
      #1;
      rstn_i = 1'b0;
      #1;
      check_eq("rst_mid_out", {ep_out_data_o, ep_out_valid_o, ep_out_ready_o, ep_out_err_o,
                               sie_out_nak_o, sie_stall_o}, 0);
      clear_model();
      @(negedge clk_i);
      idle_inputs();
      rstn_i = 1'b1;
      @(negedge clk_i);
      epq[0].push_back(8'h77);
      do_in(0, 0, 1'b0);
      do_out(1, 1, 1'b0, 1'b0, 8'h88, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
